// File: rtl/proc_io_pkg.sv
// proc_io_pkg: sample type and processor port-map constants
// shared by the processor input-side buffer.
package proc_io_pkg;

  localparam int PROC_DW = 32;

  typedef logic signed [PROC_DW-1:0] sample_t;

  // processor port map
  localparam int       PROC_IN_PORT     = 0;
  localparam int       PROC_REQ_IN_BIT  = 0;
  localparam int       PROC_OUT_PORT    = 1;
  localparam int       PROC_OUT_EN_VAL  = 2;

endpackage

// File: rtl/proc_in_fifo_if.sv
// proc_in_fifo_if: valid/ready sample stream from the
// acquisition side into the processor input buffer.
interface proc_in_fifo_if
  #(parameter int DW = proc_io_pkg::PROC_DW)
  ();

  logic signed [DW-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/proc_in_fifo_mem.sv
// proc_in_fifo_mem: DEPTH x DW simple dual-port storage,
// synchronous write, asynchronous read of the head entry.
module proc_in_fifo_mem
  #(parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH))
  (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
  );

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_in_fifo.sv
// proc_in_fifo: FWFT input buffer feeding processor port 0.
// PROC_IN_FIFO_STATS_EN adds pop / empty-read counters.
module proc_in_fifo
  import proc_io_pkg::*;
  #(parameter int DW        = PROC_DW,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12)
  (
    input  logic                         clk,
    input  logic                         rst,
    proc_in_fifo_if.slave                s,
    input  logic                         proc_req_in,
    output logic signed [DW-1:0]         proc_io_in,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         afull,
    output logic                         underflow,
    input  logic                         clr_flags
`ifdef PROC_IN_FIFO_STATS_EN
    ,
    output logic [31:0]                  rd_cnt,
    output logic [15:0]                  uf_cnt
`endif
  );

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level_nxt;
  logic [DW-1:0] head;
  logic [DW-1:0] last_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          rd_empty;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign s.s_ready = !full && !rst;
  assign push     = s.s_valid && s.s_ready;
  assign pop      = proc_req_in && !empty;
  assign rd_empty = proc_req_in && empty;

  // empty reads hold the last delivered sample
  assign proc_io_in = empty ? last_q : head;

  proc_in_fifo_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (s.s_data),
    .raddr (rptr),
    .rdata (head)
  );

  always_comb begin
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      afull     <= 1'b0;
      last_q    <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr   <= rptr + AW'(1);
        last_q <= head;
      end
      level <= level_nxt;
      afull <= (level_nxt >= LW'(AFULL_LVL));
      if (clr_flags)     underflow <= 1'b0;
      else if (rd_empty) underflow <= 1'b1;
    end
  end

`ifdef PROC_IN_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || clr_flags) begin
      rd_cnt <= '0;
      uf_cnt <= '0;
    end else begin
      if (pop) rd_cnt <= rd_cnt + 32'd1;
      if (rd_empty && uf_cnt != 16'hFFFF)
        uf_cnt <= uf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_proc_in_fifo.sv
// tb_proc_in_fifo: directed vectors for the processor
// input buffer with hand-computed expectations.
module tb_proc_in_fifo;
  import proc_io_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic           clk;
  logic           rst;
  logic           proc_req_in;
  sample_t        proc_io_in;
  logic [4:0]     level;
  logic           afull;
  logic           underflow;
  logic           clr_flags;
`ifdef PROC_IN_FIFO_STATS_EN
  logic [31:0]    rd_cnt;
  logic [15:0]    uf_cnt;
`endif

  int n_vec;
  int n_err;

  proc_in_fifo_if #(.DW(DW)) s_if ();

  proc_in_fifo #(.DW(DW), .DEPTH(DEPTH), .AFULL_LVL(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (s_if.slave),
    .proc_req_in (proc_req_in),
    .proc_io_in  (proc_io_in),
    .level       (level),
    .afull       (afull),
    .underflow   (underflow),
    .clr_flags   (clr_flags)
`ifdef PROC_IN_FIFO_STATS_EN
    ,
    .rd_cnt      (rd_cnt),
    .uf_cnt      (uf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    proc_req_in = 1'b0;
    clr_flags = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data = '0;
    tick();
    tick();
    check("rst_s_ready", s_if.s_ready, 0);
    check("rst_level", level, 0);
    check("rst_io", proc_io_in, 0);
    check("rst_afull", afull, 0);
    check("rst_uf", underflow, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", s_if.s_ready, 1);

    // three pushes, no reads
    s_if.s_valid = 1'b1;
    s_if.s_data = 100;
    tick();
    check("first_visible", proc_io_in, 100);
    s_if.s_data = -5;
    tick();
    s_if.s_data = 7;
    tick();
    s_if.s_valid = 1'b0;
    check("p3_level", level, 3);
    check("p3_io", proc_io_in, 100);
    check("p3_uf", underflow, 0);

    // three reads then hold
    proc_req_in = 1'b1;
    tick();
    check("rd1_io", proc_io_in, -5);
    tick();
    check("rd2_io", proc_io_in, 7);
    tick();
    check("rd3_io", proc_io_in, 7);
    check("rd3_level", level, 0);
    check("rd3_uf", underflow, 0);

    // read while empty
    tick();
    check("uf_io", proc_io_in, 7);
    check("uf_set", underflow, 1);
    check("uf_level", level, 0);
`ifdef PROC_IN_FIFO_STATS_EN
    check("uf_cnt1", uf_cnt, 1);
    check("rd_cnt3", rd_cnt, 3);
`endif
    proc_req_in = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("clr_uf", underflow, 0);

    // clear beats a same-cycle empty read
    proc_req_in = 1'b1;
    clr_flags = 1'b1;
    tick();
    proc_req_in = 1'b0;
    clr_flags = 1'b0;
    check("clr_wins", underflow, 0);
`ifdef PROC_IN_FIFO_STATS_EN
    check("clr_ufcnt", uf_cnt, 0);
`endif

    // fill to full
    s_if.s_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_if.s_data = i;
      tick();
      check("fill_level", level, i);
      check("fill_afull", afull, (i >= 12) ? 1 : 0);
    end
    check("full_ready", s_if.s_ready, 0);
    s_if.s_data = 17;
    tick();
    check("held_level", level, 16);
    check("held_head", proc_io_in, 1);
    proc_req_in = 1'b1;
    tick();
    proc_req_in = 1'b0;
    #1;
    check("pop_full_lvl", level, 15);
    check("ready_back", s_if.s_ready, 1);
    check("pop_full_io", proc_io_in, 2);
    tick();
    s_if.s_valid = 1'b0;
    check("s17_level", level, 16);

    // drain and verify order
    proc_req_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("drain_io", proc_io_in, k + 2);
      tick();
    end
    proc_req_in = 1'b0;
    check("drain_level", level, 0);
    check("drain_last", proc_io_in, 17);

    // steady state at level 5
    s_if.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_if.s_data = 1000 + i;
      tick();
    end
    s_if.s_valid = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("l5_level", level, 5);
    s_if.s_valid = 1'b1;
    proc_req_in = 1'b1;
    for (int c = 0; c < 200; c++) begin
      s_if.s_data = 1005 + c;
      check("stream_io", proc_io_in, 1000 + c);
      tick();
      check("stream_lvl", level, 5);
    end
    s_if.s_valid = 1'b0;
    proc_req_in = 1'b0;
`ifdef PROC_IN_FIFO_STATS_EN
    check("rd_cnt200", rd_cnt, 200);
`endif
    check("stream_head", proc_io_in, 1200);

    // reset at level 9
    s_if.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_if.s_data = 2000 + i;
      tick();
    end
    s_if.s_valid = 1'b0;
    check("l9_level", level, 9);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", s_if.s_ready, 0);
    tick();
    check("mid_rst_level", level, 0);
    check("mid_rst_io", proc_io_in, 0);
    check("mid_rst_afull", afull, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready1", s_if.s_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
